issue_sequencer: RTL and testbench

ISSUE_SEQUENCER -- requirements
Module: issue_sequencer

---
 rtl/issue_sequencer_pkg.sv | 13 +
 rtl/issue_decode.sv | 24 ++
 rtl/issue_sequencer.sv | 80 ++++++++
 tb/tb_issue_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/issue_sequencer_pkg.sv
// issue_sequencer_pkg: opcodes, FSM states and fault causes shared by the issue sequencer
package issue_sequencer_pkg;
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ALU  = 3'b001;
  localparam logic [2:0] OP_LD   = 3'b010;
  localparam logic [2:0] OP_ST   = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b100;
  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ISEGV   = 2'b01;
  localparam logic [1:0] FC_DSEGV   = 2'b10;
  localparam logic [1:0] FC_ILLEGAL = 2'b11;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT, S_FAULT} state_t;
endpackage

// File: rtl/issue_decode.sv
// issue_decode: combinational field extraction (w: instruction word -> opcode, alu_config, const_c, a/b/d selects)
module issue_decode
  import issue_sequencer_pkg::*;
#(
  parameter int IW = 32,
  parameter int RW = 4
) (
  input  logic [IW-1:0] w,
  output logic [2:0]    opcode,
  output logic [3:0]    alu_config,
  output logic          const_c,
  output logic [RW-1:0] a_select,
  output logic [RW-1:0] b_select,
  output logic [RW-1:0] d_select
);
  logic unused_low_bits;
  assign opcode          = w[IW-1 -: 3];
  assign alu_config      = w[IW-4 -: 4];
  assign const_c         = w[IW-8];
  assign a_select        = w[IW-9 -: RW];
  assign b_select        = w[IW-9-RW -: RW];
  assign d_select        = w[IW-9-2*RW -: RW];
  assign unused_low_bits = ^w;
endmodule

// File: rtl/issue_sequencer.sv
// issue_sequencer: fetch/decode/exec/mem sequencer (fetch and data handshakes in; field selects, pulses, status, retire count out)
module issue_sequencer
  import issue_sequencer_pkg::*;
#(
  parameter int IW   = 32,
  parameter int NREG = 16,
  parameter int CW   = 32,
  localparam int RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instruction,
  input  logic          wait_instr,
  input  logic          instr_segv,
  input  logic          wait_data,
  input  logic          data_segv,
  output logic          instr_req,
  output logic          pc_inc,
  output logic [2:0]    opcode,
  output logic [3:0]    alu_config,
  output logic          const_c,
  output logic [RW-1:0] a_select,
  output logic [RW-1:0] b_select,
  output logic [RW-1:0] d_select,
  output logic          reg_write,
  output logic          ld,
  output logic          st,
  output logic          halted,
  output logic          fault,
  output logic [1:0]    fault_cause,
  output logic [CW-1:0] retired
);
  state_t        state;
  logic [IW-1:0] word;
  logic          mem_done;
  issue_decode #(.IW(IW), .RW(RW)) u_decode (
    .w(word), .opcode(opcode), .alu_config(alu_config), .const_c(const_c),
    .a_select(a_select), .b_select(b_select), .d_select(d_select)
  );
  // Pulses are gated by rst so a reset landing on a completing cycle aborts it cleanly.
  assign mem_done  = !rst && state == S_MEM && !wait_data && !data_segv;
  assign instr_req = !rst && state == S_FETCH;
  assign ld        = !rst && state == S_MEM && opcode == OP_LD;
  assign st        = !rst && state == S_MEM && opcode == OP_ST;
  assign pc_inc    = mem_done || (!rst && (state == S_EXEC || (state == S_DECODE && opcode == OP_NOP)));
  assign reg_write = (mem_done && opcode == OP_LD) || (!rst && state == S_EXEC);
  assign halted    = state == S_HALT;
  assign fault     = state == S_FAULT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      word        <= '0;
      fault_cause <= FC_NONE;
      retired     <= '0;
    end else begin
      if (pc_inc) retired <= retired + CW'(1);
      case (state)
        S_FETCH: if (!wait_instr) begin
          word <= instruction;
          if (instr_segv) begin
            state       <= S_FAULT;
            fault_cause <= FC_ISEGV;
          end else state <= S_DECODE;
        end
        S_DECODE: if (opcode > OP_HALT) begin
          state       <= S_FAULT;
          fault_cause <= FC_ILLEGAL;
        end else state <= opcode == OP_NOP ? S_FETCH : opcode == OP_ALU ? S_EXEC : opcode == OP_HALT ? S_HALT : S_MEM;
        S_EXEC: state <= S_FETCH;
        S_MEM: if (!wait_data) begin
          if (data_segv) begin
            state       <= S_FAULT;
            fault_cause <= FC_DSEGV;
          end else state <= S_FETCH;
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_issue_sequencer.sv
// tb_issue_sequencer: directed scenario bench for issue_sequencer (default params plus a CW=4 instance)
module tb_issue_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        wait_instr, instr_segv, wait_data, data_segv;
  logic        instr_req, pc_inc, const_c, reg_write, ld, st, halted, fault;
  logic [2:0]  opcode;
  logic [3:0]  alu_config, a_select, b_select, d_select;
  logic [1:0]  fault_cause;
  logic [31:0] retired;
  logic        instr_req_4, pc_inc_4, const_c_4, reg_write_4, ld_4, st_4, halted_4, fault_4;
  logic [2:0]  opcode_4;
  logic [3:0]  alu_config_4, a_select_4, b_select_4, d_select_4;
  logic [1:0]  fault_cause_4;
  logic [3:0]  retired_4;
  int checks = 0;
  int errors = 0;
  int ld_cycles;

  always #5 clk = ~clk;

  issue_sequencer dut (
    .clk(clk), .rst(rst), .instruction(instruction), .wait_instr(wait_instr),
    .instr_segv(instr_segv), .wait_data(wait_data), .data_segv(data_segv),
    .instr_req(instr_req), .pc_inc(pc_inc), .opcode(opcode), .alu_config(alu_config),
    .const_c(const_c), .a_select(a_select), .b_select(b_select), .d_select(d_select),
    .reg_write(reg_write), .ld(ld), .st(st), .halted(halted), .fault(fault),
    .fault_cause(fault_cause), .retired(retired)
  );

  issue_sequencer #(.CW(4)) dut4 (
    .clk(clk), .rst(rst), .instruction(instruction), .wait_instr(wait_instr),
    .instr_segv(instr_segv), .wait_data(wait_data), .data_segv(data_segv),
    .instr_req(instr_req_4), .pc_inc(pc_inc_4), .opcode(opcode_4), .alu_config(alu_config_4),
    .const_c(const_c_4), .a_select(a_select_4), .b_select(b_select_4), .d_select(d_select_4),
    .reg_write(reg_write_4), .ld(ld_4), .st(st_4), .halted(halted_4), .fault(fault_4),
    .fault_cause(fault_cause_4), .retired(retired_4)
  );

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [3:0] alu, input logic c,
                                     input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    return {op, alu, c, a, b, d, 12'h000};
  endfunction

  task automatic idle;
    wait_instr = 1'b0; instr_segv = 1'b0; wait_data = 1'b0; data_segv = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1; idle();
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; idle(); instruction = 32'hFFFF_FFFF;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (instr_req !== 1'b0) begin errors++; $display("FAIL reset_instr_req: got %0d expected 0", instr_req); end
    checks++; if ({pc_inc, reg_write, ld, st} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {pc_inc, reg_write, ld, st}); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    checks++; if ({fault, halted, fault_cause} !== 4'b0) begin errors++; $display("FAIL reset_status: got %b expected 0000", {fault, halted, fault_cause}); end
    checks++; if ({opcode, alu_config, const_c, a_select, b_select, d_select} !== 20'h0) begin errors++; $display("FAIL reset_fields: got %h expected 0", {opcode, alu_config, const_c, a_select, b_select, d_select}); end
    rst = 1'b0; #1;
    checks++; if (instr_req !== 1'b1) begin errors++; $display("FAIL reset_release_instr_req: got %0d expected 1", instr_req); end
  endtask

  task automatic test_alu;
    instruction = 32'h2A12_3000; #1;
    checks++; if (pc_inc !== 1'b0) begin errors++; $display("FAIL alu_fetch_pc_inc: got %0d expected 0", pc_inc); end
    @(negedge clk); #1;
    checks++; if (opcode !== 3'b001 || alu_config !== 4'b0101 || const_c !== 1'b0) begin errors++; $display("FAIL alu_decode_op: got %b/%b/%b expected 001/0101/0", opcode, alu_config, const_c); end
    checks++; if (a_select !== 4'd1 || b_select !== 4'd2 || d_select !== 4'd3) begin errors++; $display("FAIL alu_decode_sel: got %0d/%0d/%0d expected 1/2/3", a_select, b_select, d_select); end
    checks++; if ({instr_req, pc_inc, reg_write} !== 3'b000) begin errors++; $display("FAIL alu_decode_pulses: got %b expected 000", {instr_req, pc_inc, reg_write}); end
    @(negedge clk); #1;
    checks++; if ({reg_write, pc_inc} !== 2'b11) begin errors++; $display("FAIL alu_exec_pulses: got %b expected 11", {reg_write, pc_inc}); end
    @(negedge clk); #1;
    checks++; if (retired !== 32'd1) begin errors++; $display("FAIL alu_retired: got %0d expected 1", retired); end
    checks++; if (instr_req !== 1'b1 || d_select !== 4'd3) begin errors++; $display("FAIL alu_back_to_fetch: got req=%0d d=%0d expected req=1 d=3", instr_req, d_select); end
  endtask

  task automatic test_nop;
    instruction = mk(3'b000, 4'hA, 1'b1, 4'd15, 4'd0, 4'd7); #1;
    @(negedge clk); #1;
    checks++; if ({pc_inc, reg_write} !== 2'b10) begin errors++; $display("FAIL nop_decode_pulses: got %b expected 10", {pc_inc, reg_write}); end
    checks++; if (const_c !== 1'b1 || a_select !== 4'd15 || alu_config !== 4'hA) begin errors++; $display("FAIL nop_fields: got c=%0d a=%0d alu=%h expected c=1 a=15 alu=a", const_c, a_select, alu_config); end
    @(negedge clk); #1;
    checks++; if (retired !== 32'd2 || instr_req !== 1'b1) begin errors++; $display("FAIL nop_retire: got ret=%0d req=%0d expected ret=2 req=1", retired, instr_req); end
  endtask

  task automatic test_ld_wait;
    instruction = mk(3'b010, 4'h0, 1'b0, 4'd4, 4'd0, 4'd9);
    wait_instr = 1'b1; instr_segv = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (instr_req !== 1'b1) begin errors++; $display("FAIL ld_fetch_wait_req: got %0d expected 1", instr_req); end
      @(negedge clk);
    end
    wait_instr = 1'b0; instr_segv = 1'b0; #1;
    @(negedge clk);
    wait_data = 1'b1; data_segv = 1'b1; #1;
    checks++; if (ld !== 1'b0 || opcode !== 3'b010 || d_select !== 4'd9) begin errors++; $display("FAIL ld_decode: got ld=%0d op=%b d=%0d expected ld=0 op=010 d=9", ld, opcode, d_select); end
    @(negedge clk);
    ld_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      wait_data = (i < 4); data_segv = (i < 4); #1;
      if (ld === 1'b1) ld_cycles++;
      checks++; if (reg_write !== (i == 4) || pc_inc !== (i == 4)) begin errors++; $display("FAIL ld_mem_cycle%0d: got wr=%0d inc=%0d expected %0d", i, reg_write, pc_inc, (i == 4)); end
      @(negedge clk);
    end
    idle(); #1;
    checks++; if (ld_cycles !== 5) begin errors++; $display("FAIL ld_high_cycles: got %0d expected 5", ld_cycles); end
    checks++; if (retired !== 32'd3 || instr_req !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL ld_retire: got ret=%0d req=%0d fault=%0d expected 3/1/0", retired, instr_req, fault); end
  endtask

  task automatic test_st;
    instruction = mk(3'b011, 4'h0, 1'b0, 4'd2, 4'd6, 4'd0); #1;
    @(negedge clk); #1;
    checks++; if (st !== 1'b0) begin errors++; $display("FAIL st_decode_st: got %0d expected 0", st); end
    @(negedge clk); #1;
    checks++; if ({st, ld, pc_inc, reg_write} !== 4'b1010) begin errors++; $display("FAIL st_mem: got %b expected 1010", {st, ld, pc_inc, reg_write}); end
    @(negedge clk); #1;
    checks++; if (retired !== 32'd4) begin errors++; $display("FAIL st_retire: got %0d expected 4", retired); end
  endtask

  task automatic test_st_segv;
    instruction = mk(3'b011, 4'h0, 1'b0, 4'd1, 4'd1, 4'd1); #1;
    @(negedge clk); @(negedge clk);
    data_segv = 1'b1; #1;
    checks++; if ({st, pc_inc, reg_write} !== 3'b100) begin errors++; $display("FAIL st_segv_mem: got %b expected 100", {st, pc_inc, reg_write}); end
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      wait_instr = i[0]; instr_segv = i[1]; wait_data = i[2]; data_segv = i[3]; #1;
      checks++; if (fault !== 1'b1 || fault_cause !== 2'b10) begin errors++; $display("FAIL st_segv_fault%0d: got %0d/%b expected 1/10", i, fault, fault_cause); end
      checks++; if ({instr_req, pc_inc, reg_write, ld, st} !== 5'b0 || retired !== 32'd4) begin errors++; $display("FAIL st_segv_frozen%0d: got %b ret=%0d expected 00000 ret=4", i, {instr_req, pc_inc, reg_write, ld, st}, retired); end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_illegal;
    do_reset();
    instruction = mk(3'b111, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0); #1;
    @(negedge clk); #1;
    checks++; if ({pc_inc, reg_write, fault} !== 3'b000 || opcode !== 3'b111) begin errors++; $display("FAIL illegal_decode: got %b op=%b expected 000 op=111", {pc_inc, reg_write, fault}, opcode); end
    @(negedge clk); #1;
    checks++; if (fault !== 1'b1 || fault_cause !== 2'b11 || halted !== 1'b0) begin errors++; $display("FAIL illegal_fault: got %0d/%b/%0d expected 1/11/0", fault, fault_cause, halted); end
  endtask

  task automatic test_instr_segv;
    do_reset();
    instruction = mk(3'b001, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    wait_instr = 1'b1; instr_segv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (instr_req !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL isegv_ignored%0d: got req=%0d fault=%0d expected 1/0", i, instr_req, fault); end
      @(negedge clk);
    end
    wait_instr = 1'b0; #1;
    @(negedge clk); instr_segv = 1'b0; #1;
    checks++; if (fault !== 1'b1 || fault_cause !== 2'b01 || instr_req !== 1'b0) begin errors++; $display("FAIL isegv_fault: got %0d/%b req=%0d expected 1/01 req=0", fault, fault_cause, instr_req); end
  endtask

  task automatic test_wrap_halt;
    do_reset();
    instruction = mk(3'b000, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      #1; @(negedge clk); #1;
      checks++; if (pc_inc_4 !== 1'b1) begin errors++; $display("FAIL wrap_nop%0d_pc_inc: got %0d expected 1", i, pc_inc_4); end
      @(negedge clk);
    end
    #1;
    checks++; if (retired_4 !== 4'd0) begin errors++; $display("FAIL wrap_retired4: got %0d expected 0", retired_4); end
    checks++; if (retired !== 32'd16) begin errors++; $display("FAIL wrap_retired32: got %0d expected 16", retired); end
    instruction = mk(3'b100, 4'h0, 1'b0, 4'd0, 4'd0, 4'd0); #1;
    @(negedge clk); #1;
    checks++; if (pc_inc_4 !== 1'b0) begin errors++; $display("FAIL halt_decode_pc_inc: got %0d expected 0", pc_inc_4); end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (halted_4 !== 1'b1 || retired_4 !== 4'd0 || {instr_req_4, pc_inc_4, reg_write_4, ld_4, st_4, fault_4} !== 6'b0) begin errors++; $display("FAIL halt_hold%0d: got h=%0d ret=%0d sig=%b expected 1/0/000000", i, halted_4, retired_4, {instr_req_4, pc_inc_4, reg_write_4, ld_4, st_4, fault_4}); end
      @(negedge clk);
    end
  endtask

  task automatic test_rst_mid_mem;
    do_reset();
    instruction = mk(3'b001, 4'h3, 1'b0, 4'd1, 4'd1, 4'd1); #1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    instruction = mk(3'b010, 4'h0, 1'b1, 4'd8, 4'd8, 4'd8); #1;
    @(negedge clk); wait_data = 1'b1;
    @(negedge clk); #1;
    checks++; if (ld !== 1'b1 || retired !== 32'd1) begin errors++; $display("FAIL rst_mem_setup: got ld=%0d ret=%0d expected 1/1", ld, retired); end
    @(negedge clk);
    rst = 1'b1; wait_data = 1'b0; #1;
    checks++; if ({reg_write, pc_inc} !== 2'b00) begin errors++; $display("FAIL rst_mem_abort: got %b expected 00", {reg_write, pc_inc}); end
    @(negedge clk); #1;
    checks++; if (retired !== 32'd0 || {opcode, const_c, d_select} !== 8'h0 || {instr_req, ld, fault, halted} !== 4'b0) begin errors++; $display("FAIL rst_mem_values: got ret=%0d f=%h s=%b expected 0/0/0000", retired, {opcode, const_c, d_select}, {instr_req, ld, fault, halted}); end
    rst = 1'b0; #1;
    checks++; if (instr_req !== 1'b1) begin errors++; $display("FAIL rst_mem_release: got %0d expected 1", instr_req); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_nop();
    test_ld_wait();
    test_st();
    test_st_segv();
    test_illegal();
    test_instr_segv();
    test_wrap_halt();
    test_rst_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
